// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state type and constants for uart_tx_arbiter
package uart_arb_pkg;
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, ACK} arb_state_t;
  localparam logic [7:0] HEADER_BASE = 8'hA0;
  localparam int START_TIMEOUT = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req above last_idx, wrapping
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_idx,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] c;
  always_comb begin
    gnt_valid = |req;
    gnt_idx = '0;
    c = '0;
    for (int k = NUM_REQ; k > 0; k--) begin
      c = IW'((int'(last_idx) + k) % NUM_REQ);
      gnt_idx = req[c] ? c : gnt_idx;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX byte channel, MSB byte first; UART_ARB_HEADER_EN prepends 0xA0|idx
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WORD_BYTES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*WORD_BYTES*8-1:0] word_in,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_idx,
  output logic                            tx_start,
  output logic [7:0]                      tx_data,
  input  logic                            tx_ready
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(WORD_BYTES + 1) + 1;
`ifdef UART_ARB_HEADER_EN
  localparam int TOTAL = WORD_BYTES + 1;
`else
  localparam int TOTAL = WORD_BYTES;
`endif
  localparam int SW = TOTAL * 8;
  arb_state_t state;
  logic [SW-1:0] sh, sh_next, sh_load;
  logic [CW-1:0] byte_cnt;
  logic [IW-1:0] last_idx, gnt_idx;
  logic [2:0] tmo;
  logic gnt_valid;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req(req),
    .last_idx(last_idx),
    .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx)
  );
  assign busy = state != IDLE;
  assign sh_next = sh << 8;
`ifdef UART_ARB_HEADER_EN
  assign sh_load = {HEADER_BASE | 8'(gnt_idx), word_in[gnt_idx*WORD_BYTES*8 +: WORD_BYTES*8]};
`else
  assign sh_load = word_in[gnt_idx*WORD_BYTES*8 +: WORD_BYTES*8];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      byte_cnt <= '0;
      last_idx <= IW'(NUM_REQ - 1);
      grant_idx <= '0;
      tmo <= '0;
      tx_start <= 1'b0;
      tx_data <= '0;
      done <= '0;
    end else begin
      tx_start <= 1'b0;
      done <= '0;
      case (state)
        IDLE: if (gnt_valid && tx_ready) begin
          sh <= sh_load;
          grant_idx <= gnt_idx;
          byte_cnt <= '0;
          tx_start <= 1'b1;
          tx_data <= sh_load[SW-1 -: 8];
          state <= START;
        end
        START: begin
          tmo <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (!tx_ready) state <= WAIT_DONE;
        else if (tmo == 3'(START_TIMEOUT - 1)) begin
          tx_start <= 1'b1;
          tx_data <= sh[SW-1 -: 8];
          state <= START;
        end else tmo <= tmo + 1'b1;
        WAIT_DONE: if (tx_ready) begin
          sh <= sh_next;
          byte_cnt <= byte_cnt + 1'b1;
          if (byte_cnt == CW'(TOTAL - 1)) begin
            done <= NUM_REQ'(1) << grant_idx;
            state <= ACK;
          end else begin
            tx_start <= 1'b1;
            tx_data <= sh_next[SW-1 -: 8];
            state <= START;
          end
        end
        ACK: begin
          last_idx <= grant_idx;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
